step_dispatcher: RTL and testbench
==================================

# step_dispatcher

Upstream feeder for the step controller. It accepts bytes on a valid/ready input stream and buffers them in a small FIFO. It issues each byte to the controller as a one-cycle `ctl_start` with `ctl_data`, waits for the controller's `ctl_done` pulse, and returns the captured result on a valid/ready output stream. A per-job watchdog reports hung jobs as error results, so a stalled controller cannot block the stream silently.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `TIMEOUT`, 255: maximum number of WAIT cycles before a job is declared timed out; range 1..255.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: FIFO not full.
- `in_data` in 8: input byte.
- `ctl_start` out 1: one-cycle job start to the controller.
- `ctl_data` out 8: job operand; valid while `ctl_start`=1.
- `ctl_result` in 8: controller result; sampled only when `ctl_done`=1.
- `ctl_done` in 1: controller completion pulse.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 8: result byte.
- `out_err` out 1: qualifies `out_data`; 1 = timed out, and `out_data` is 8'hFF.
- `busy` out 1: FIFO non-empty or state != IDLE.
- `stale_cnt` out 8: saturating count of `ctl_done` pulses received outside WAIT.

## Operation
- **FIFO**
  - Circular buffer with `DEPTH` entries; head and tail pointers are log2(DEPTH) bits and wrap naturally.
  - Count is log2(DEPTH)+1 bits.
  - Push when `in_valid` && `in_ready`, with `in_ready` = (count != DEPTH).
  - When full, `in_ready`=0 even if a pop occurs in the same cycle. Capacity is not bypassed.
  - A pop occurs only in ISSUE. Push and pop in the same cycle leave count unchanged.
- **FSM states:** IDLE, ISSUE, WAIT, HOLD.
  - IDLE -> ISSUE when count != 0.
  - ISSUE lasts exactly 1 cycle:
    - `ctl_start`=1 and `ctl_data` = FIFO head (both combinational from state and head).
    - Pop the head.
    - Clear the watchdog counter to 0.
    - Go to WAIT.
  - WAIT:
    - The watchdog counter (8 bits) increments each cycle.
    - If `ctl_done`=1: register `out_data` <= `ctl_result`, `out_err` <= 0, go to HOLD.
    - Otherwise, when watchdog == `TIMEOUT`-1: `out_data` <= 8'hFF, `out_err` <= 1, go to HOLD.
    - If `ctl_done` arrives in the timeout cycle, `ctl_done` wins.
  - HOLD:
    - `out_valid`=1; `out_data` and `out_err` are held stable.
    - On `out_ready`: go to ISSUE if count != 0, else to IDLE.
- **Stale results:** a `ctl_done` in IDLE, ISSUE or HOLD is discarded. `stale_cnt` increments and saturates at 8'hFF. This covers the late completion of a timed-out job.
- **Ordering:** exactly one job is outstanding at a time. Results leave in input order.
- **Reset:** async reset clears the FIFO, pointers, state, `out_data`, `out_err`, watchdog and `stale_cnt`, and abandons any in-flight job.

## Timing
- **Reset values:**
  - `in_ready`=1, because the FIFO is empty.
  - `ctl_start`=0, `ctl_data`=8'h00, `out_valid`=0, `out_data`=8'h00, `out_err`=0, `busy`=0, `stale_cnt`=0.
- **Input to start:** a byte accepted in cycle N from an empty, IDLE block gives `ctl_start`=1 in cycle N+2.
- **Done to output:** `ctl_done` in WAIT cycle M gives `out_valid`=1 from cycle M+1.
- **Timeout:** with no `ctl_done`, WAIT lasts exactly `TIMEOUT` cycles. `out_valid` rises in cycle ISSUE+`TIMEOUT`+1.
- **Back-to-back jobs:** `out_ready`=1 in HOLD with the FIFO non-empty gives the next `ctl_start` the following cycle. Minimum job period is 3 cycles plus the controller latency.
- **Start spacing:** `ctl_start` is never asserted in two consecutive cycles, and is never asserted while a job is outstanding.

## Test plan
The bench's controller model returns `ctl_result` = `ctl_data` ^ 8'h5A, pulsing `ctl_done` 6 cycles after `ctl_start`.
- **Single job:** push 8'h12 with `out_ready`=1.
  - `ctl_start` 2 cycles after the accept, with `ctl_data`=8'h12.
  - `out_valid` with `out_data`=8'h48 and `out_err`=0.
  - `busy` returns to 0.
- **FIFO fill:** hold `out_ready`=0 and push 8'h01..8'h06.
  - Bytes 8'h01..8'h05 are accepted: one issued plus 4 buffered.
  - `in_ready`=0 while 8'h06 waits.
  - Release `out_ready`: results 8'h5B, 8'h58, 8'h59, 8'h5E, 8'h5F, 8'h5C, in order.
- **Timeout:** the model never responds, with `TIMEOUT`=255.
  - `out_valid` with `out_data`=8'hFF and `out_err`=1 exactly 256 cycles after `ctl_start`.
  - A later `ctl_done` increments `stale_cnt` to 1 and produces no output.
- **Done versus timeout collision:** `TIMEOUT`=8, model latency 7 cycles after start, so `ctl_done` lands in the timeout cycle.
  - The genuine result is returned with `out_err`=0.
- **Output backpressure:** `out_ready`=0 for 20 cycles in HOLD.
  - `out_data` is stable throughout.
  - No `ctl_start` is issued.
  - The next `ctl_start` follows the cycle after `out_ready`=1.
- **Reset mid-job:** assert `rst_n`=0 during WAIT with 3 bytes queued.
  - All outputs are at their reset values immediately, and the FIFO is empty.
  - After release, `ctl_done` increments `stale_cnt` only.

Source files
------------

// File: rtl/step_dispatcher.sv
// rtl/step_dispatcher.sv - byte FIFO feeding a one-job-at-a-time step controller
// Watchdog turns a hung job into an error result so the output stream keeps moving.
module step_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       ctl_start,
    output logic [7:0] ctl_data,
    input  logic [7:0] ctl_result,
    input  logic       ctl_done,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_err,
    output logic       busy,
    output logic [7:0] stale_cnt
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [7:0]    WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic [7:0]    r_wdog;
    logic [7:0]    r_out_data;
    logic          r_out_err;
    logic [7:0]    r_stale;
    logic          w_push;
    logic          w_pop;
    logic          w_done_cap;
    logic          w_timeout_cap;

    // Full means not ready even if ISSUE pops this cycle: no bypass of capacity.
    assign in_ready  = (r_count != FULL);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = (r_state == S_ISSUE);
    assign ctl_start = w_pop;
    assign ctl_data  = w_pop ? r_mem[r_head] : 8'h00;
    assign out_valid = (r_state == S_HOLD);
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign busy      = (r_count != '0) || (r_state != S_IDLE);
    assign stale_cnt = r_stale;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_done_cap    = 1'b0;
        w_timeout_cap = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the timeout cycle still wins over the watchdog.
                if (ctl_done) begin
                    w_done_cap   = 1'b1;
                    w_next_state = S_HOLD;
                end else if (r_wdog == WD_LAST) begin
                    w_timeout_cap = 1'b1;
                    w_next_state  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_next_state = (r_count != '0) ? S_ISSUE : S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= in_data;
                r_tail        <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog     <= 8'h00;
            r_out_data <= 8'h00;
            r_out_err  <= 1'b0;
            r_stale    <= 8'h00;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wdog <= 8'h00;
            end else if (r_state == S_WAIT) begin
                r_wdog <= r_wdog + 8'd1;
            end
            if (w_done_cap) begin
                r_out_data <= ctl_result;
                r_out_err  <= 1'b0;
            end else if (w_timeout_cap) begin
                r_out_data <= 8'hFF;
                r_out_err  <= 1'b1;
            end
            // Completions outside WAIT (e.g. late reply to a timed-out job) are only counted.
            if (ctl_done && (r_state != S_WAIT) && (r_stale != 8'hFF)) begin
                r_stale <= r_stale + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_step_dispatcher.sv
// tb/tb_step_dispatcher.sv - directed bench for step_dispatcher with a xor-5A controller model
module tb_step_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       ctl_start;
    logic [7:0] ctl_data;
    logic [7:0] ctl_result = 8'h00;
    logic       ctl_done = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_err;
    logic       busy;
    logic [7:0] stale_cnt;

    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [7:0] b_in_data = 8'h00;
    logic       b_ctl_start;
    logic [7:0] b_ctl_data;
    logic [7:0] b_ctl_result = 8'h00;
    logic       b_ctl_done = 1'b0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b1;
    logic [7:0] b_out_data;
    logic       b_out_err;
    logic       b_busy;
    logic [7:0] b_stale_cnt;

    int checks = 0;
    int errors = 0;
    int viol = 0;

    always #5 clk = ~clk;

    step_dispatcher #(.DEPTH(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ctl_start(ctl_start), .ctl_data(ctl_data),
        .ctl_result(ctl_result), .ctl_done(ctl_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err),
        .busy(busy), .stale_cnt(stale_cnt)
    );

    step_dispatcher #(.DEPTH(4), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .ctl_start(b_ctl_start), .ctl_data(b_ctl_data),
        .ctl_result(b_ctl_result), .ctl_done(b_ctl_done),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_err(b_out_err),
        .busy(b_busy), .stale_cnt(b_stale_cnt)
    );

    // Controller models: start seen at an edge, done pulses L cycles later, result = data ^ 5A.
    logic       m_respond = 1'b1;
    int         m_cnt = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_st;
    logic [7:0] m_d;
    always @(posedge clk) begin
        m_st = ctl_start;
        m_d  = ctl_data;
        #1;
        ctl_done = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                ctl_done   = 1'b1;
                ctl_result = m_data ^ 8'h5A;
            end
        end
        if (m_st && m_respond) begin
            m_cnt  = 6;
            m_data = m_d;
        end
    end

    int         mb_cnt = 0;
    logic [7:0] mb_data = 8'h00;
    logic       mb_st;
    logic [7:0] mb_d;
    always @(posedge clk) begin
        mb_st = b_ctl_start;
        mb_d  = b_ctl_data;
        #1;
        b_ctl_done = 1'b0;
        if (mb_cnt > 0) begin
            mb_cnt--;
            if (mb_cnt == 0) begin
                b_ctl_done   = 1'b1;
                b_ctl_result = mb_data ^ 8'h5A;
            end
        end
        if (mb_st) begin
            mb_cnt  = 7;
            mb_data = mb_d;
        end
    end

    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    always @(negedge clk) begin
        if (ctl_start && prev_a) viol++;
        if (b_ctl_start && prev_b) viol++;
        prev_a = ctl_start;
        prev_b = b_ctl_start;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic test_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (ctl_start !== 1'b0)   begin errors++; $display("FAIL reset_ctl_start: got %b want 0", ctl_start); end
        checks++; if (ctl_data !== 8'h00)   begin errors++; $display("FAIL reset_ctl_data: got %h want 00", ctl_data); end
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00)   begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (out_err !== 1'b0)     begin errors++; $display("FAIL reset_out_err: got %b want 0", out_err); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (stale_cnt !== 8'h00)  begin errors++; $display("FAIL reset_stale: got %h want 00", stale_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int k;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (ctl_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b want 0", ctl_start); end
        @(negedge clk);
        checks++; if (ctl_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", ctl_start); end
        checks++; if (ctl_data !== 8'h12) begin errors++; $display("FAIL single_ctl_data: got %h want 12", ctl_data); end
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        checks++; if (k != 8) begin errors++; $display("FAIL single_latency: got %0d want 8", k); end
        checks++; if (out_data !== 8'h48) begin errors++; $display("FAIL single_out_data: got %h want 48", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL single_out_err: got %b want 0", out_err); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_fill();
        logic [7:0] exp [6];
        logic [7:0] got [6];
        int   n;
        logic acc;
        logic stuck;
        logic any_err;
        exp[0] = 8'h5B; exp[1] = 8'h58; exp[2] = 8'h59;
        exp[3] = 8'h5E; exp[4] = 8'h5F; exp[5] = 8'h5C;
        out_ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'(b);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_accept_%0d: got %b want 1", b, in_ready); end
        end
        @(negedge clk);
        in_data = 8'h06;
        stuck = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (in_ready !== 1'b0) stuck = 1'b1;
            @(negedge clk);
        end
        checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL fill_in_ready_full: got ready-seen=%b want 0", stuck); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_first_held: got %b want 1", out_valid); end
        out_ready = 1'b1;
        n = 0; acc = 1'b0; any_err = 1'b0;
        for (int i = 0; i < 200 && n < 6; i++) begin
            if (acc) in_valid = 1'b0;
            acc = in_valid && in_ready;
            if (out_valid) begin
                got[n] = out_data;
                any_err |= out_err;
                n++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (n != 6) begin errors++; $display("FAIL fill_count: got %0d want 6", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL fill_result_%0d: got %h want %h", i, got[i], exp[i]); end
        end
        checks++; if (any_err !== 1'b0) begin errors++; $display("FAIL fill_err: got %b want 0", any_err); end
    endtask

    task automatic test_back_to_back();
        int   k;
        int   hold_bad;
        int   start_bad;
        out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = 8'hAA;
        @(negedge clk); in_data = 8'hBB;
        @(negedge clk); in_valid = 1'b0;
        for (k = 0; k < 40; k++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 8'hF0) begin errors++; $display("FAIL bp_first_data: got %h want F0", out_data); end
        hold_bad = 0; start_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 8'hF0) hold_bad++;
            if (ctl_start !== 1'b0) start_bad++;
        end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d bad cycles want 0", hold_bad); end
        checks++; if (start_bad != 0) begin errors++; $display("FAIL bp_no_start: got %0d start cycles want 0", start_bad); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (ctl_start !== 1'b1) begin errors++; $display("FAIL bp_next_start: got %b want 1", ctl_start); end
        checks++; if (ctl_data !== 8'hBB) begin errors++; $display("FAIL bp_next_data: got %h want BB", ctl_data); end
        for (k = 0; k < 40; k++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        checks++; if (out_data !== 8'hE1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_data: got %h/%b want E1/1", out_data, out_valid); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int   k;
        int   bad;
        m_respond = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b1; in_data = 8'h33;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        checks++; if (ctl_start !== 1'b1) begin errors++; $display("FAIL to_start: got %b want 1", ctl_start); end
        for (k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        checks++; if (k != 256) begin errors++; $display("FAIL to_latency: got %0d want 256", k); end
        checks++; if (out_data !== 8'hFF) begin errors++; $display("FAIL to_out_data: got %h want FF", out_data); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL to_out_err: got %b want 1", out_err); end
        @(negedge clk);
        ctl_result = 8'h77; ctl_done = 1'b1;
        @(negedge clk);
        ctl_done = 1'b0;
        checks++; if (stale_cnt !== 8'h01) begin errors++; $display("FAIL to_stale: got %h want 01", stale_cnt); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0 || stale_cnt !== 8'h01) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL to_late_no_output: got %0d bad cycles want 0", bad); end
        m_respond = 1'b1;
    endtask

    task automatic test_collision();
        int k;
        @(negedge clk); b_in_valid = 1'b1; b_in_data = 8'h3C;
        @(negedge clk); b_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (b_ctl_start !== 1'b1) begin errors++; $display("FAIL col_start: got %b want 1", b_ctl_start); end
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (b_out_valid) break;
        end
        checks++; if (k != 9) begin errors++; $display("FAIL col_latency: got %0d want 9", k); end
        checks++; if (b_out_data !== 8'h66) begin errors++; $display("FAIL col_out_data: got %h want 66", b_out_data); end
        checks++; if (b_out_err !== 1'b0) begin errors++; $display("FAIL col_out_err: got %b want 0", b_out_err); end
        checks++; if (b_stale_cnt !== 8'h00) begin errors++; $display("FAIL col_stale: got %h want 00", b_stale_cnt); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        int bad;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'(8'h10 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before: got %b want 1", busy); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
        checks++; if (ctl_start !== 1'b0)  begin errors++; $display("FAIL rm_ctl_start: got %b want 0", ctl_start); end
        checks++; if (ctl_data !== 8'h00)  begin errors++; $display("FAIL rm_ctl_data: got %h want 00", ctl_data); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL rm_out_data: got %h want 00", out_data); end
        checks++; if (out_err !== 1'b0)    begin errors++; $display("FAIL rm_out_err: got %b want 0", out_err); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
        checks++; if (stale_cnt !== 8'h00) begin errors++; $display("FAIL rm_stale: got %h want 00", stale_cnt); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || ctl_start !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rm_quiet_after: got %0d bad cycles want 0", bad); end
        checks++; if (stale_cnt !== 8'h01) begin errors++; $display("FAIL rm_stale_after: got %h want 01", stale_cnt); end
    endtask

    task automatic test_start_spacing();
        checks++; if (viol != 0) begin errors++; $display("FAIL start_spacing: got %0d adjacent starts want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_timeout();
        test_collision();
        test_reset_mid_job();
        test_start_spacing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
